// File: rtl/fire_seq.sv
`default_nettype none
// ============================================================================
// Module   : fire_seq
// Purpose  : Transmit-side stimulus sequencer for the CDC hazard-measurement
//            blocks. Emits one-cycle `fire` strobes with single, periodic,
//            burst or LFSR-random spacing. It counts every strobe in `sent`
//            and signals the end of a campaign with a one-cycle `done`.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CNT_W  : width of total / sent (and sent_gray)
//   GAP_W  : width of the gap field (1..16)
// Ports
//   clk        in   single clock, all logic on posedge
//   resetn     in   synchronous active-low reset
//   start      in   campaign request, sampled only while idle
//   abort      in   stops a running campaign (no done)
//   mode       in   0 single, 1 periodic, 2 burst, 3 LFSR random
//   gap        in   periodic gap (mode 1) or gap mask (mode 3)
//   total      in   fires per campaign for modes 1-3
//   seed       in   LFSR seed for mode 3 (0 is replaced by 1)
//   fire       out  registered one-cycle strobe
//   busy       out  campaign in progress
//   done       out  one-cycle completion pulse
//   sent       out  fires issued in the current or last campaign
//   sent_gray  out  gray-coded copy of sent (FIRE_SEQ_GRAY_OUT_EN only)
// Optional feature macro: FIRE_SEQ_GRAY_OUT_EN
// ============================================================================
module fire_seq #(
  parameter int CNT_W = 32,
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [GAP_W-1:0] gap,
  input  logic [CNT_W-1:0] total,
  input  logic [15:0]      seed,
  output logic             fire,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent
`ifdef FIRE_SEQ_GRAY_OUT_EN
  ,
  output logic [CNT_W-1:0] sent_gray
`endif
);

  localparam logic [1:0]  MODE_SINGLE = 2'd0;
  localparam logic [1:0]  MODE_PERIOD = 2'd1;
  localparam logic [1:0]  MODE_RANDOM = 2'd3;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [15:0] LFSR_INIT   = 16'h0001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Galois right-shift step of the 16-bit LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    lfsr_step = l[0] ? ((l >> 1) ^ LFSR_TAPS) : (l >> 1);
  endfunction

  state_t           state_q,     state_d;
  logic [1:0]       mode_q,      mode_d;
  logic [GAP_W-1:0] gap_q,       gap_d;
  logic [CNT_W-1:0] tot_q,       tot_d;
  logic [15:0]      lfsr_q,      lfsr_d;
  logic [GAP_W-1:0] cnt_q,       cnt_d;
  logic             fire_q,      fire_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic [CNT_W-1:0] sent_q,      sent_d;
`ifdef FIRE_SEQ_GRAY_OUT_EN
  logic [CNT_W-1:0] sent_gray_q, sent_gray_d;
`endif

  // While idle the campaign settings come straight from the inputs, because
  // they are latched on the same edge that issues the first fire.
  logic             in_idle;
  logic [1:0]       mode_src;
  logic [GAP_W-1:0] gap_src;
  logic [15:0]      seed_eff;
  logic [15:0]      lfsr_src;
  logic [15:0]      lfsr_adv;
  logic [GAP_W-1:0] lfsr_bits;
  logic [GAP_W-1:0] gap_eff;
  logic [CNT_W-1:0] total_eff;

  assign in_idle   = (state_q == S_IDLE);
  assign mode_src  = in_idle ? mode : mode_q;
  assign gap_src   = in_idle ? gap  : gap_q;
  assign seed_eff  = (seed == 16'd0) ? LFSR_INIT : seed;
  assign lfsr_src  = in_idle ? seed_eff : lfsr_q;
  assign lfsr_adv  = lfsr_step(lfsr_src);
  assign lfsr_bits = GAP_W'(lfsr_adv);
  assign total_eff = (mode == MODE_SINGLE) ? CNT_W'(1) : total;

  // Spacing that follows the fire being issued now. In random mode the mask
  // is applied to the LFSR value *after* this fire's advance.
  always_comb begin
    gap_eff = '0;
    if (mode_src == MODE_PERIOD) begin
      gap_eff = gap_src;
    end else if (mode_src == MODE_RANDOM) begin
      gap_eff = lfsr_bits & gap_src;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    logic issue;

    state_d = state_q;
    mode_d  = mode_q;
    gap_d   = gap_q;
    tot_d   = tot_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    fire_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    sent_d  = sent_q;
    issue   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          mode_d = mode;
          gap_d  = gap;
          tot_d  = total_eff;
          lfsr_d = seed_eff;
          sent_d = '0;
          if (total_eff == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            issue = 1'b1;
          end
        end
      end

      S_FIRE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (sent_q == tot_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (cnt_q == '0) begin
          issue = 1'b1;
        end else begin
          // cnt_q already holds this fire's gap; GAP counts it down.
          state_d = S_GAP;
          busy_d  = 1'b1;
        end
      end

      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == GAP_W'(1)) begin
          issue = 1'b1;
        end else begin
          cnt_d  = cnt_q - GAP_W'(1);
          busy_d = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Common path for every fire: count it, step the LFSR in random mode
    // and remember the spacing to the next fire.
    if (issue) begin
      state_d = S_FIRE;
      fire_d  = 1'b1;
      busy_d  = 1'b1;
      sent_d  = sent_d + CNT_W'(1);
      cnt_d   = gap_eff;
      if (mode_src == MODE_RANDOM) begin
        lfsr_d = lfsr_adv;
      end else begin
        lfsr_d = lfsr_src;
      end
    end
  end

`ifdef FIRE_SEQ_GRAY_OUT_EN
  always_comb begin
    sent_gray_d = sent_d ^ (sent_d >> 1);
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'd0;
      gap_q       <= '0;
      tot_q       <= '0;
      lfsr_q      <= LFSR_INIT;
      cnt_q       <= '0;
      fire_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sent_q      <= '0;
`ifdef FIRE_SEQ_GRAY_OUT_EN
      sent_gray_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      gap_q       <= gap_d;
      tot_q       <= tot_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      fire_q      <= fire_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sent_q      <= sent_d;
`ifdef FIRE_SEQ_GRAY_OUT_EN
      sent_gray_q <= sent_gray_d;
`endif
    end
  end

  assign fire = fire_q;
  assign busy = busy_q;
  assign done = done_q;
  assign sent = sent_q;
`ifdef FIRE_SEQ_GRAY_OUT_EN
  assign sent_gray = sent_gray_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fire_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fire_seq
// Purpose  : Self-checking bench for fire_seq. A queue-based model derives
//            the fire cycles and the done cycle of each campaign from the
//            mode / gap / total / seed rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fire_seq;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        abort;
  logic [1:0]  mode;
  logic [7:0]  gap;
  logic [31:0] total;
  logic [15:0] seed;
  logic        fire;
  logic        busy;
  logic        done;
  logic [31:0] sent;
`ifdef FIRE_SEQ_GRAY_OUT_EN
  logic [31:0] sent_gray;
`endif

  fire_seq #(.CNT_W(32), .GAP_W(8)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .abort    (abort),
    .mode     (mode),
    .gap      (gap),
    .total    (total),
    .seed     (seed),
    .fire     (fire),
    .busy     (busy),
    .done     (done),
    .sent     (sent)
`ifdef FIRE_SEQ_GRAY_OUT_EN
    ,
    .sent_gray(sent_gray)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model results
  int exp_fire[$];
  int exp_done;
  // Observations (cycle 1 = first cycle after the start edge)
  int obs_fire[$];
  int obs_sent[$];
  int obs_done[$];
  int busy_cnt;
  int busy_last;

  // Reference: the k-th fire lands gap_eff+1 cycles after the previous one,
  // with the first fire one cycle after start and done one cycle after the last.
  task automatic model(input logic [1:0] m, input logic [7:0] g,
                       input logic [31:0] t, input logic [15:0] s);
    int n;
    int c;
    int ge;
    logic [15:0] l;
    exp_fire.delete();
    n = (m == 2'd0) ? 1 : int'(t);
    l = (s == 16'd0) ? 16'h0001 : s;
    c = 1;
    for (int k = 0; k < n; k++) begin
      exp_fire.push_back(c);
      if (m == 2'd3) l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
      case (m)
        2'd1:    ge = int'(g);
        2'd3:    ge = int'(l[7:0] & g);
        default: ge = 0;
      endcase
      c += ge + 1;
    end
    exp_done = (n == 0) ? 1 : exp_fire[n-1] + 1;
  endtask

  // Drive one start and record ncyc cycles of outputs. abort is held high
  // during cycle abort_cyc (0 = never).
  task automatic launch(input logic [1:0] m, input logic [7:0] g,
                        input logic [31:0] t, input logic [15:0] s,
                        input int ncyc, input int abort_cyc);
    obs_fire.delete();
    obs_sent.delete();
    obs_done.delete();
    busy_cnt  = 0;
    busy_last = 0;
    mode  = m;
    gap   = g;
    total = t;
    seed  = s;
    abort = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (fire) begin
        obs_fire.push_back(c);
        obs_sent.push_back(int'(sent));
      end
      if (done) obs_done.push_back(c);
      if (busy) begin
        busy_cnt++;
        busy_last = c;
      end
      abort = (c == abort_cyc);
      @(posedge clk); #1;
    end
    abort = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    mode   = 2'd0;
    gap    = 8'd0;
    total  = 32'd0;
    seed   = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({fire, busy, done} !== 3'b000)
      $display("FAIL reset_flags: fire/busy/done=%b expected 000", {fire, busy, done});
    else n_pass++;
    n_checks++;
    if (sent !== 32'd0) $display("FAIL reset_sent: got %0d expected 0", sent);
    else n_pass++;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_campaign(input logic [1:0] m, input logic [7:0] g,
                               input logic [31:0] t, input logic [15:0] s);
    int n;
    int lastf;
    model(m, g, t, s);
    launch(m, g, t, s, exp_done + 3, 0);
    n = exp_fire.size();
    lastf = (n == 0) ? 0 : exp_fire[n-1];

    n_checks++;
    if (obs_fire.size() != n)
      $display("FAIL fire_count m%0d g%0d t%0d s%h: got %0d expected %0d",
               m, g, t, s, obs_fire.size(), n);
    else n_pass++;
    for (int i = 0; i < n && i < obs_fire.size(); i++) begin
      n_checks++;
      if (obs_fire[i] != exp_fire[i])
        $display("FAIL fire_cycle[%0d] m%0d: got %0d expected %0d", i, m, obs_fire[i], exp_fire[i]);
      else n_pass++;
      n_checks++;
      if (obs_sent[i] != i + 1)
        $display("FAIL sent_at_fire[%0d] m%0d: got %0d expected %0d", i, m, obs_sent[i], i + 1);
      else n_pass++;
    end
    n_checks++;
    if (obs_done.size() != 1 || obs_done[0] != exp_done)
      $display("FAIL done_cycle m%0d t%0d: got %0d pulses first %0d expected one at %0d",
               m, t, obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1, exp_done);
    else n_pass++;
    n_checks++;
    if (busy_cnt != lastf || busy_last != lastf)
      $display("FAIL busy_window m%0d: got %0d cycles ending %0d expected %0d ending %0d",
               m, busy_cnt, busy_last, lastf, lastf);
    else n_pass++;
    n_checks++;
    if (sent !== 32'(n)) $display("FAIL final_sent m%0d: got %0d expected %0d", m, sent, n);
    else n_pass++;
`ifdef FIRE_SEQ_GRAY_OUT_EN
    n_checks++;
    if (sent_gray !== (32'(n) ^ (32'(n) >> 1)))
      $display("FAIL sent_gray: got %h expected %h", sent_gray, 32'(n) ^ (32'(n) >> 1));
    else n_pass++;
`endif
  endtask

  task automatic test_directed;
    test_campaign(2'd0, 8'd0,  32'd0, 16'h0000);   // single
    test_campaign(2'd1, 8'd3,  32'd4, 16'h0000);   // periodic 1,5,9,13
    test_campaign(2'd2, 8'd0,  32'd5, 16'h0000);   // burst 1..5
    test_campaign(2'd3, 8'h07, 32'd4, 16'hACE1);   // random 1,2,3,8
    test_campaign(2'd2, 8'd0,  32'd0, 16'h0000);   // zero total
    test_campaign(2'd3, 8'hFF, 32'd3, 16'h0000);   // zero seed
  endtask

  task automatic test_random;
    logic [1:0]  m;
    logic [7:0]  g;
    logic [31:0] t;
    logic [15:0] s;
    for (int it = 0; it < 14; it++) begin
      m = 2'($urandom_range(0, 3));
      g = (m == 2'd3) ? 8'($urandom) : 8'($urandom_range(0, 12));
      t = 32'($urandom_range(0, 8));
      s = (it == 3) ? 16'd0 : 16'($urandom);
      test_campaign(m, g, t, s);
    end
  endtask

  task automatic test_abort;
    launch(2'd1, 8'd9, 32'd10, 16'h0000, 20, 7);
    n_checks++;
    if (obs_fire.size() != 1 || obs_fire[0] != 1)
      $display("FAIL abort_fires: got %0d fires expected 1 at cycle 1", obs_fire.size());
    else n_pass++;
    n_checks++;
    if (busy_last != 7 || busy_cnt != 7)
      $display("FAIL abort_busy: got last %0d count %0d expected 7/7", busy_last, busy_cnt);
    else n_pass++;
    n_checks++;
    if (obs_done.size() != 0)
      $display("FAIL abort_done: got %0d pulses expected 0", obs_done.size());
    else n_pass++;
    n_checks++;
    if (sent !== 32'd1) $display("FAIL abort_sent: got %0d expected 1", sent);
    else n_pass++;
    // A fresh campaign afterwards must restart cleanly.
    test_campaign(2'd2, 8'd0, 32'd2, 16'h0000);
  endtask

  task automatic test_reset_mid_gap;
    mode  = 2'd1;
    gap   = 8'd9;
    total = 32'd10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);   // now in the gap
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({fire, busy, done} !== 3'b000 || sent !== 32'd0)
      $display("FAIL reset_mid_gap: fire/busy/done=%b sent=%0d expected 000/0",
               {fire, busy, done}, sent);
    else n_pass++;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_start_abort_ignored;
    int seen;
    seen  = 0;
    mode  = 2'd2;
    total = 32'd5;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (fire || busy || done) seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen != 0) $display("FAIL start_abort_ignored: got %0d active cycles expected 0", seen);
    else n_pass++;
    n_checks++;
    if (sent !== 32'd0) $display("FAIL start_abort_sent: got %0d expected 0", sent);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_reset_mid_gap();
    test_start_abort_ignored();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/fire_seq.md
Name: fire_seq

Overview:
- Single-clock stimulus sequencer that drives the `fire` strobe into the CDC hazard-measurement blocks (gray/naive signal crossers); it is the transmit-side counterpart of the hazard counters.
- Generates one-cycle `fire` pulses in single, periodic, burst or LFSR-random spacing, and counts the pulses it sends.
- Reports completion with a one-cycle `done`, so a campaign's sent count can be compared against the receive-side hazard counts.

Parameters:
- CNT_W, 32: width of `total` and `sent`.
- GAP_W, 8: width of the gap field; legal range 1..16.

Ports:
- clk, input, 1: the block's single clock; all logic is posedge.
- resetn, input, 1: synchronous, active-low reset.
- start, input, 1: campaign request; sampled only in IDLE.
- abort, input, 1: stops a running campaign.
- mode, input, 2: 0 single, 1 periodic, 2 burst, 3 random.
- gap, input, GAP_W: periodic gap in modes 1 and 3; in mode 3 it is a mask.
- total, input, CNT_W: number of fires for modes 1-3.
- seed, input, 16: LFSR seed for mode 3.
- fire, output, 1: registered one-cycle strobe.
- busy, output, 1: campaign in progress.
- done, output, 1: one-cycle completion pulse.
- sent, output, CNT_W: number of fires issued in the current or last campaign.

Behaviour:
- Reset (resetn=0 at a posedge): state goes to IDLE. fire=0, busy=0, done=0, sent=0, LFSR=0x0001. Reset mid-campaign aborts it with no `done`.
- States: IDLE, FIRE, GAP, DONE. All outputs are registered.
- IDLE:
  - If start=1 and abort=0, latch mode/gap/total/seed and clear sent. A seed of 0 is replaced by 0x0001.
  - Effective total: 1 in mode 0, otherwise `total`.
  - If effective total is 0, go to DONE: no fire.
  - Otherwise go to FIRE with fire=1, sent=1, busy=1 in the next cycle, i.e. 1-cycle latency from start to the first fire.
  - abort=1 with start=1 in IDLE: start is ignored.
- On every fire cycle:
  - sent already includes that fire.
  - In mode 3 the LFSR advances once. Galois right-shift: lsb=l[0]; l=l>>1; if lsb, l^=0xB400.
- Gap selection after each fire:
  - Mode 1: gap_eff = gap.
  - Mode 2: gap_eff = 0.
  - Mode 3: gap_eff = (post-advance LFSR[GAP_W-1:0]) & gap.
- Fire spacing: consecutive fire cycles are exactly gap_eff+1 cycles apart.
  - gap_eff=0 gives back-to-back fires (FIRE to FIRE).
  - Otherwise the next state is GAP with a down-counter loaded with gap_eff.
- End of campaign: after the fire where sent==effective total, go to DONE instead of GAP or FIRE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start is ignored in DONE.
- fire is never high for two cycles except in gap_eff=0 runs.
- abort=1 in FIRE or GAP:
  - Next cycle fire=0, busy=0, state IDLE; no `done`.
  - sent holds its value until the next accepted start.
- No wrap-around: sent never exceeds total, so `sent` cannot overflow.

Optional Feature:
- Macro: FIRE_SEQ_GRAY_OUT_EN.
- Defined: adds output `sent_gray` (CNT_W) = sent ^ (sent>>1).
  - Registered; updates in the same cycle as `sent`.
  - Reset value 0.
  - Used as the reference gray count for the receive side.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Mode 0, start at cycle 0 -> fire=1 at cycle 1 only, sent=1, done=1 at cycle 2, busy=1 only at cycle 1.
- Mode 1, gap=3, total=4 -> fires at cycles 1, 5, 9, 13; sent=4; done at 14; busy 1..13.
- Mode 2, total=5 -> fire high at cycles 1-5 continuously; done at 6; sent=5.
- Mode 3, seed=0xACE1, gap=0x07, total=4:
  - LFSR sequence 0xE270, 0x7138, 0x389C gives gaps 0, 0, 4.
  - Fires at cycles 1, 2, 3, 8; done at 9.
- Mode 1, gap=9, total=10, abort at cycle 7 -> fire only at cycle 1; busy=0 from cycle 8; no done; sent stays 1.
- Mode 2, total=0 -> no fire; done at cycle 1. Also check start+abort together in IDLE -> ignored. Also check resetn=0 mid-GAP -> all outputs 0 next cycle.
